// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave front end for the single-port RAM.
// Deserialises MOSI frames into FRAME_BITS command words (rx_data/rx_valid)
// and shifts RAM read data (tx_data/tx_valid) back out on MISO, MSB first.
// SCK is the system clock; SS_n and MOSI are synchronous to it.
// Optional feature macro: SPI_FRAME_ERR_EN adds the frame_err output, which
// pulses for one cycle when SS_n rises before a frame has fully completed.
module spi_slave_if #(
    parameter int FRAME_BITS = 10,
    parameter int DATA_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SS_n,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [DATA_BITS-1:0]  tx_data,
    input  logic                  tx_valid
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic                  frame_err
`endif
);

    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam int TW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
    localparam logic [TW-1:0] TX_ZERO  = TW'(0);
    localparam logic [TW-1:0] TX_ONE   = TW'(1);
    localparam logic [TW-1:0] TX_LAST  = TW'(DATA_BITS - 1);
    localparam logic [TW-1:0] TX_FULL  = TW'(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         bit_cnt_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [FRAME_BITS-1:0] shift_d;
    logic [FRAME_BITS-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  rd_addr_seen_q;
    logic                  miso_q;
    logic [DATA_BITS-1:0]  tx_shift_q;
    logic [TW-1:0]         tx_cnt_q;
    logic                  tx_busy_q;
    logic                  tx_done_q;
`ifdef SPI_FRAME_ERR_EN
    logic                  frame_err_q;
`endif

    // Next value of the receive shift register: append MOSI as the new LSB.
    always_comb begin
        shift_d = {shift_q[FRAME_BITS-2:0], MOSI};
    end

    // Frame FSM with receive path, read-data shift-out and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bit_cnt_q      <= CNT_ZERO;
            shift_q        <= {FRAME_BITS{1'b0}};
            rx_data_q      <= {FRAME_BITS{1'b0}};
            rx_valid_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            miso_q         <= 1'b0;
            tx_shift_q     <= {DATA_BITS{1'b0}};
            tx_cnt_q       <= TX_ZERO;
            tx_busy_q      <= 1'b0;
            tx_done_q      <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err_q    <= 1'b0;
`endif
        end else begin
            // Strobes default low so they can never stretch past one cycle.
            rx_valid_q <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    bit_cnt_q <= CNT_ZERO;
                    miso_q    <= 1'b0;
                    tx_cnt_q  <= TX_ZERO;
                    tx_busy_q <= 1'b0;
                    tx_done_q <= 1'b0;
                    if (SS_n == 1'b0) begin
                        state_q <= CHK_CMD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CHK_CMD: begin
                    // MOSI in this cycle is the mode bit, not part of the frame.
                    if (SS_n == 1'b1) begin
                        state_q <= IDLE;
                    end else if (MOSI == 1'b0) begin
                        state_q <= WRITE;
                    end else if (rd_addr_seen_q == 1'b0) begin
                        state_q <= READ_ADD;
                    end else begin
                        state_q <= READ_DATA;
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (SS_n == 1'b1) begin
                        // End of frame or abort; rd_addr_seen is left untouched.
                        state_q   <= IDLE;
                        bit_cnt_q <= CNT_ZERO;
                        miso_q    <= 1'b0;
                        tx_busy_q <= 1'b0;
                        tx_done_q <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
                        if (state_q == READ_DATA) begin
                            frame_err_q <= ~tx_done_q;
                        end else begin
                            frame_err_q <= (bit_cnt_q != CNT_FULL);
                        end
`endif
                    end else if (bit_cnt_q != CNT_FULL) begin
                        bit_cnt_q <= bit_cnt_q + CNT_ONE;
                        shift_q   <= shift_d;
                        miso_q    <= 1'b0;
                        if (bit_cnt_q == CNT_LAST) begin
                            rx_data_q  <= shift_d;
                            rx_valid_q <= 1'b1;
                            if (state_q == READ_ADD) begin
                                rd_addr_seen_q <= 1'b1;
                            end else if (state_q == READ_DATA) begin
                                rd_addr_seen_q <= 1'b0;
                            end else begin
                                rd_addr_seen_q <= rd_addr_seen_q;
                            end
                        end
                    end else if (state_q == READ_DATA) begin
                        // Frame received: return one RAM read word, then idle MISO low.
                        if (tx_busy_q) begin
                            if (tx_cnt_q != TX_FULL) begin
                                miso_q     <= tx_shift_q[DATA_BITS-1];
                                tx_shift_q <= {tx_shift_q[DATA_BITS-2:0], 1'b0};
                                tx_cnt_q   <= tx_cnt_q + TX_ONE;
                                if (tx_cnt_q == TX_LAST) begin
                                    tx_done_q <= 1'b1;
                                end
                            end else begin
                                miso_q    <= 1'b0;
                                tx_busy_q <= 1'b0;
                            end
                        end else if (tx_valid == 1'b1 && tx_done_q == 1'b0) begin
                            miso_q     <= tx_data[DATA_BITS-1];
                            tx_shift_q <= {tx_data[DATA_BITS-2:0], 1'b0};
                            tx_cnt_q   <= TX_ONE;
                            tx_busy_q  <= 1'b1;
                        end else begin
                            miso_q <= 1'b0;
                        end
                    end else begin
                        // Overlong WRITE/READ_ADD bits are ignored.
                        miso_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    bit_cnt_q <= CNT_ZERO;
                    miso_q    <= 1'b0;
                    tx_busy_q <= 1'b0;
                    tx_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`ifdef SPI_FRAME_ERR_EN
    assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed testbench for spi_slave_if: write, read, abort, reset, overlong frames.
module tb_spi_slave_if;

    localparam int FB = 10;
    localparam int DB = 8;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          SS_n     = 1'b1;
    logic          MOSI     = 1'b0;
    logic          MISO;
    logic [FB-1:0] rx_data;
    logic          rx_valid;
    logic [DB-1:0] tx_data  = 8'h00;
    logic          tx_valid = 1'b0;
`ifdef SPI_FRAME_ERR_EN
    logic          frame_err;
    int            fe_cnt   = 0;
`endif

    int            tests_run    = 0;
    int            tests_failed = 0;
    int            rv_cnt       = 0;
    int            rv_double    = 0;
    int            miso_hi_cnt  = 0;
    logic          rv_prev      = 1'b0;
    logic [FB-1:0] rv_last_data = 10'h000;

    always #5 clk = ~clk;

    spi_slave_if #(.FRAME_BITS(FB), .DATA_BITS(DB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    // Event monitor: counts strobes and MISO-high cycles shortly after each edge.
    always @(posedge clk) begin
        #2;
        if (rx_valid === 1'b1) begin
            rv_cnt       <= rv_cnt + 1;
            rv_last_data <= rx_data;
            if (rv_prev) rv_double <= rv_double + 1;
        end
        rv_prev <= (rx_valid === 1'b1);
        if (MISO === 1'b1) miso_hi_cnt <= miso_hi_cnt + 1;
`ifdef SPI_FRAME_ERR_EN
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
`endif
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    // Select, send mode bit, then nbits frame bits MSB first; ends at the negedge after the last bit.
    task automatic send_frame(input logic mode, input logic [15:0] bits, input int nbits);
        SS_n = 1'b0; MOSI = 1'b0; cyc();
        MOSI = mode; cyc();
        for (int i = nbits - 1; i >= 0; i--) begin
            MOSI = bits[i];
            cyc();
        end
        MOSI = 1'b0;
    endtask

    task automatic end_frame();
        SS_n = 1'b1; MOSI = 1'b0; cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        cyc(); cyc();
        tests_run++;
        if (MISO !== 1'b0) begin tests_failed++; $display("FAIL reset_miso: got %b want 0", MISO); end
        tests_run++;
        if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        tests_run++;
        if (rx_data !== 10'h000) begin tests_failed++; $display("FAIL reset_rx_data: got %h want 000", rx_data); end
        rst_n = 1'b1; cyc();
    endtask

    task automatic test_write_addr();
        int r0 = rv_cnt;
        int m0 = miso_hi_cnt;
        send_frame(1'b0, 16'h0005, 10);
        tests_run++;
        if (rx_valid !== 1'b1) begin tests_failed++; $display("FAIL wr_addr_valid: got %b want 1", rx_valid); end
        tests_run++;
        if (rx_data !== 10'h005) begin tests_failed++; $display("FAIL wr_addr_data: got %h want 005", rx_data); end
        tx_valid = 1'b1; tx_data = 8'hFF; cyc();
        tx_valid = 1'b0;
        tests_run++;
        if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL wr_addr_valid_drop: got %b want 0", rx_valid); end
        cyc();
        end_frame();
        tests_run++;
        if (rv_cnt - r0 != 1) begin tests_failed++; $display("FAIL wr_addr_pulses: got %0d want 1", rv_cnt - r0); end
        tests_run++;
        if (miso_hi_cnt != m0) begin tests_failed++; $display("FAIL wr_addr_miso: got %0d high cycles want 0", miso_hi_cnt - m0); end
    endtask

    task automatic test_write_data();
        int r0 = rv_cnt;
`ifdef SPI_FRAME_ERR_EN
        int f0 = fe_cnt;
`endif
        send_frame(1'b0, 16'h01AA, 10);
        end_frame();
        tests_run++;
        if (rv_cnt - r0 != 1) begin tests_failed++; $display("FAIL wr_data_pulses: got %0d want 1", rv_cnt - r0); end
        tests_run++;
        if (rv_last_data !== 10'h1AA) begin tests_failed++; $display("FAIL wr_data_word: got %h want 1aa", rv_last_data); end
        tests_run++;
        if (rx_data !== 10'h1AA) begin tests_failed++; $display("FAIL wr_data_hold: got %h want 1aa", rx_data); end
`ifdef SPI_FRAME_ERR_EN
        tests_run++;
        if (fe_cnt != f0) begin tests_failed++; $display("FAIL wr_data_no_err: got %0d frame_err want 0", fe_cnt - f0); end
`endif
    endtask

    task automatic test_read();
        logic [DB-1:0] exp = 8'hAA;
        int r0 = rv_cnt;
        int m0;
        send_frame(1'b1, 16'h0205, 10);
        end_frame();
        tests_run++;
        if (rv_last_data !== 10'h205 || rv_cnt - r0 != 1) begin
            tests_failed++; $display("FAIL rd_addr_frame: got %h x%0d want 205 x1", rv_last_data, rv_cnt - r0);
        end
        send_frame(1'b1, 16'h03C7, 10);
        tests_run++;
        if (rx_valid !== 1'b1 || rx_data !== 10'h3C7) begin
            tests_failed++; $display("FAIL rd_data_frame: got %b/%h want 1/3c7", rx_valid, rx_data);
        end
        tests_run++;
        if (MISO !== 1'b0) begin tests_failed++; $display("FAIL rd_wait_miso: got %b want 0", MISO); end
        tx_valid = 1'b1; tx_data = exp; cyc();
        tx_valid = 1'b0; tx_data = 8'h00;
        for (int i = DB - 1; i >= 0; i--) begin
            tests_run++;
            if (MISO !== exp[i]) begin tests_failed++; $display("FAIL rd_miso_bit%0d: got %b want %b", i, MISO, exp[i]); end
            cyc();
        end
        tests_run++;
        if (MISO !== 1'b0) begin tests_failed++; $display("FAIL rd_miso_after: got %b want 0", MISO); end
        m0 = miso_hi_cnt;
        tx_valid = 1'b1; tx_data = 8'hFF; cyc();
        tx_valid = 1'b0; cyc(); cyc();
        tests_run++;
        if (miso_hi_cnt != m0) begin tests_failed++; $display("FAIL rd_second_tx_valid: got %0d high cycles want 0", miso_hi_cnt - m0); end
        end_frame();
        // rd_addr_seen must be clear: a mode-1 frame is now an address frame, so no read return.
        m0 = miso_hi_cnt;
        send_frame(1'b1, 16'h0211, 10);
        tx_valid = 1'b1; tx_data = 8'hFF; cyc();
        tx_valid = 1'b0; cyc(); cyc();
        tests_run++;
        if (miso_hi_cnt != m0) begin tests_failed++; $display("FAIL rd_addr_seen_clear: got %0d high cycles want 0", miso_hi_cnt - m0); end
        end_frame();
    endtask

    task automatic test_abort();
        int r0 = rv_cnt;
        int m0;
        logic [5:0] part = 6'b101101;
`ifdef SPI_FRAME_ERR_EN
        int f0 = fe_cnt;
`endif
        SS_n = 1'b0; cyc();
        MOSI = 1'b0; cyc();
        for (int i = 5; i >= 0; i--) begin MOSI = part[i]; cyc(); end
        end_frame();
        tests_run++;
        if (rv_cnt != r0) begin tests_failed++; $display("FAIL abort_no_valid: got %0d pulses want 0", rv_cnt - r0); end
`ifdef SPI_FRAME_ERR_EN
        tests_run++;
        if (fe_cnt - f0 != 1) begin tests_failed++; $display("FAIL abort_frame_err: got %0d want 1", fe_cnt - f0); end
`endif
        send_frame(1'b0, 16'h00F3, 10);
        end_frame();
        tests_run++;
        if (rv_cnt - r0 != 1 || rv_last_data !== 10'h0F3) begin
            tests_failed++; $display("FAIL abort_next_frame: got %h x%0d want 0f3 x1", rv_last_data, rv_cnt - r0);
        end
        // rd_addr_seen is set; abort a read-data frame after 4 bits and confirm it survives.
        SS_n = 1'b0; cyc();
        MOSI = 1'b1; cyc();
        for (int i = 0; i < 4; i++) begin MOSI = 1'b1; cyc(); end
        end_frame();
        send_frame(1'b1, 16'h0300, 10);
        tx_valid = 1'b1; tx_data = 8'hFF; cyc();
        tx_valid = 1'b0;
        tests_run++;
        if (MISO !== 1'b1) begin tests_failed++; $display("FAIL abort_rd_kept_bit7: got %b want 1", MISO); end
        cyc();
        tests_run++;
        if (MISO !== 1'b1) begin tests_failed++; $display("FAIL abort_rd_kept_bit6: got %b want 1", MISO); end
        end_frame();
        tests_run++;
        if (MISO !== 1'b0) begin tests_failed++; $display("FAIL abort_shift_miso: got %b want 0", MISO); end
        m0 = miso_hi_cnt;
        cyc(); cyc();
        tests_run++;
        if (miso_hi_cnt != m0) begin tests_failed++; $display("FAIL abort_shift_stops: got %0d high cycles want 0", miso_hi_cnt - m0); end
`ifdef SPI_FRAME_ERR_EN
        tests_run++;
        if (fe_cnt - f0 != 3) begin tests_failed++; $display("FAIL abort_frame_err_total: got %0d want 3", fe_cnt - f0); end
`endif
    endtask

    task automatic test_reset_mid();
        int m0;
        send_frame(1'b1, 16'h0201, 10);
        end_frame();
        send_frame(1'b1, 16'h0300, 10);
        tx_valid = 1'b1; tx_data = 8'hFF; cyc();
        tx_valid = 1'b0;
        cyc();
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (MISO !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_miso: got %b want 0", MISO); end
        tests_run++;
        if (rx_valid !== 1'b0 || rx_data !== 10'h000) begin
            tests_failed++; $display("FAIL rst_mid_rx: got %b/%h want 0/000", rx_valid, rx_data);
        end
        @(negedge clk);
        SS_n = 1'b1; cyc();
        rst_n = 1'b1; cyc();
        // rd_addr_seen cleared by reset: mode-1 frame is an address frame, no read return.
        m0 = miso_hi_cnt;
        send_frame(1'b1, 16'h0222, 10);
        tx_valid = 1'b1; tx_data = 8'hFF; cyc();
        tx_valid = 1'b0; cyc(); cyc();
        tests_run++;
        if (miso_hi_cnt != m0 || rv_last_data !== 10'h222) begin
            tests_failed++; $display("FAIL rst_mid_rd_addr_seen: got %0d high/%h want 0/222", miso_hi_cnt - m0, rv_last_data);
        end
        end_frame();
    endtask

    task automatic test_overlong();
        int r0 = rv_cnt;
        int d0 = rv_double;
`ifdef SPI_FRAME_ERR_EN
        int f0 = fe_cnt;
`endif
        send_frame(1'b0, 16'h2B5F, 14);
        cyc();
        end_frame();
        tests_run++;
        if (rv_cnt - r0 != 1) begin tests_failed++; $display("FAIL overlong_pulses: got %0d want 1", rv_cnt - r0); end
        tests_run++;
        if (rv_last_data !== 10'h2B5 || rx_data !== 10'h2B5) begin
            tests_failed++; $display("FAIL overlong_word: got %h/%h want 2b5", rv_last_data, rx_data);
        end
        tests_run++;
        if (rv_double != d0 || rv_double != 0) begin tests_failed++; $display("FAIL rx_valid_width: got %0d double pulses want 0", rv_double); end
`ifdef SPI_FRAME_ERR_EN
        tests_run++;
        if (fe_cnt != f0) begin tests_failed++; $display("FAIL overlong_no_err: got %0d want 0", fe_cnt - f0); end
`endif
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_write_data();
        test_read();
        test_abort();
        test_reset_mid();
        test_overlong();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
